multi_reset_sequencer: RTL and testbench
========================================

Name: multi_reset_sequencer

Overview:
- Generalised successor of the two-domain reset/secure status block: tracks NUM_CH active-low domain reset requests, sequences recovery through a programmable settle window, and gates a secure flag across reset episodes.
- Reports episode/glitch counts and a cause mask on a status data word, and pulses a strobe when all domains have recovered.
- Sits between the per-domain reset sources and the security/status consumers, on the main clock.

Parameters:
- NUM_CH, 2, number of domain reset request inputs (1..8).
- CNT_W, 8, width of each saturating counter.
- DATA_W, 32, data word width; must be >= 2*CNT_W+NUM_CH.
- SETTLE_CYCLES, 4, consecutive all-released cycles required before recovery (>=1).

Ports:
- clk  input  1  clock, single domain.
- rst  input  1  synchronous, active-high global reset.
- rst_req_n  input  NUM_CH  active-low domain reset requests, synchronous to clk.
- secure_in  input  1  secure qualifier, sampled at recovery.
- clr_status  input  1  synchronous clear of counters and cause mask.
- secure_out  output  1  gated secure flag.
- status  output  1  1 = all domains operational.
- strobe  output  1  one-cycle recovery-complete pulse.
- data  output  DATA_W  status word.

Behaviour:
- All outputs are registered. rst has priority over everything.
- On rst:
  - state <= SETTLE, settle_cnt <= SETTLE_CYCLES-1.
  - secure_out, status, strobe, data, counters and cause_mask all 0.
- Data layout (unused MSBs read 0):
  - [CNT_W-1:0] = event_cnt.
  - [2*CNT_W-1:CNT_W] = glitch_cnt.
  - [2*CNT_W+NUM_CH-1:2*CNT_W] = cause_mask.
  - data is updated on the same edge as its fields.
- FSM states: IDLE, IN_RESET, SETTLE. any_low = |(~rst_req_n).
- IDLE:
  - any_low sampled -> IN_RESET.
  - event_cnt +1 (saturating).
  - cause_mask <= ~rst_req_n (cleared then loaded).
- IN_RESET:
  - cause_mask |= ~rst_req_n every edge.
  - !any_low -> SETTLE, settle_cnt <= SETTLE_CYCLES-1.
- SETTLE:
  - any_low -> IN_RESET; glitch_cnt +1 (saturating); cause_mask |= ~rst_req_n; event_cnt unchanged.
  - !any_low and settle_cnt != 0 -> decrement.
  - !any_low and settle_cnt == 0 -> IDLE; strobe <= 1 for exactly one cycle; secure_out <= secure_in; status <= 1.
- Recovery latency: if release is first sampled at edge m, strobe, status and secure_out update at edge m+SETTLE_CYCLES.
- On the edge any_low is sampled from IDLE: status <= 0 and secure_out <= 0.
  - Both stay 0 throughout IN_RESET and SETTLE.
  - secure_in is ignored outside the recovery edge.
- Counters saturate at all-ones and never wrap.
- clr_status:
  - Zeroes event_cnt, glitch_cnt and cause_mask.
  - If an increment or mask load occurs on the same edge, the clear is applied first and the new event is then applied (result count = 1).
  - Does not affect state, status, secure_out or strobe.
- Simultaneous channel assertions count as one episode. Channels asserting later in the same episode only OR into cause_mask.
- rst asserted mid-operation aborts any sequence.
  - After rst releases, SETTLE->IN_RESET counts as a glitch, not an event.
  - Power-on recovery does not increment event_cnt.

Test Plan (NUM_CH=2, CNT_W=8, DATA_W=32, SETTLE_CYCLES=4):
1. Power-on recovery: rst high 3 edges with rst_req_n=2'b11 and secure_in=1, then rst low.
   - strobe on the 4th edge after release; status=1, secure_out=1, data=0x0000_0000.
2. Single-channel episode: from IDLE, rst_req_n=2'b10 for 3 cycles with secure_in=1, then 2'b11.
   - status and secure_out drop on the first low edge.
   - strobe 4 edges after release; data=0x0001_0001.
3. Glitch during settle: continuing from 2, rst_req_n=2'b01, release, then 2'b10 on the 2nd SETTLE cycle, then release.
   - data=0x0003_0102.
   - strobe only after 4 clean cycles following the final release.
4. Saturation: 300 episodes with both channels low together.
   - event_cnt=0xFF with no wrap; cause_mask=2'b11.
5. Clear with new episode: clr_status high on the same edge a new episode starts from IDLE.
   - event_cnt=1, glitch_cnt=0, cause_mask = the newly asserted channels.
6. Reset mid-episode: rst pulsed during IN_RESET while rst_req_n=2'b10 is held.
   - Outputs are 0 after rst.
   - On the next edge: state IN_RESET, data=0x0001_0100.
   - No strobe until 4 edges after the channel releases.

Source files
------------

// File: rtl/multi_reset_sequencer_if.sv
// Signal bundle between the domain reset sources and the sequencer.
// master drives the requests/qualifiers; slave is the sequencer itself.
interface multi_reset_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0] rst_req_n;
    logic              secure_in;
    logic              clr_status;
    logic              secure_out;
    logic              status;
    logic              strobe;
    logic [DATA_W-1:0] data;

    modport master (
        output rst_req_n, secure_in, clr_status,
        input  secure_out, status, strobe, data
    );

    modport slave (
        input  rst_req_n, secure_in, clr_status,
        output secure_out, status, strobe, data
    );
endinterface

// File: rtl/multi_reset_sequencer.sv
// Multi-domain reset sequencer: tracks active-low domain reset requests, waits out a
// settle window before declaring recovery, and gates a secure flag across episodes.

// Saturating counter with a clear that takes effect before the same-edge increment.
module mrs_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic [W-1:0] q_nxt
);
    logic [W-1:0] base;

    always_comb begin
        base  = clr ? '0 : q;
        q_nxt = base;
        if (inc && (base != {W{1'b1}}))
            q_nxt = base + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= q_nxt;
    end
endmodule

// One cause-mask bit: cleared-and-loaded at episode start, sticky-OR while active.
module mrs_cause_lane (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic accum,
    input  logic req_low,
    output logic q,
    output logic q_nxt
);
    logic base;

    always_comb begin
        base  = clr ? 1'b0 : q;
        q_nxt = base;
        if (load)       q_nxt = req_low;
        else if (accum) q_nxt = base | req_low;
    end

    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= q_nxt;
    end
endmodule

module multi_reset_sequencer #(
    parameter int NUM_CH        = 2,
    parameter int CNT_W         = 8,
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    multi_reset_sequencer_if.slave   bus
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_RESET = 2'd1,
        SETTLE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic              status_q, status_d;
    logic              secure_q, secure_d;
    logic              strobe_q, strobe_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [NUM_CH-1:0] req_low;
    logic              any_low;
    logic              ev_inc, gl_inc, mask_load, mask_accum;

    logic [CNT_W-1:0]  ev_q, ev_nxt;
    logic [CNT_W-1:0]  gl_q, gl_nxt;
    logic [NUM_CH-1:0] mask_q, mask_nxt;

    assign req_low = ~bus.rst_req_n;
    assign any_low = |req_low;

    // Next-state and control decode.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        status_d   = status_q;
        secure_d   = secure_q;
        strobe_d   = 1'b0;
        ev_inc     = 1'b0;
        gl_inc     = 1'b0;
        mask_load  = 1'b0;
        mask_accum = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_low) begin
                    state_d   = IN_RESET;
                    ev_inc    = 1'b1;
                    mask_load = 1'b1;
                    status_d  = 1'b0;
                    secure_d  = 1'b0;
                end
            end
            IN_RESET: begin
                mask_accum = 1'b1;
                if (!any_low) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (any_low) begin
                    // A re-assertion before the window closes is a glitch, not a new episode.
                    state_d    = IN_RESET;
                    gl_inc     = 1'b1;
                    mask_accum = 1'b1;
                end else if (settle_q != '0) begin
                    settle_d = settle_q - SW'(1);
                end else begin
                    state_d  = IDLE;
                    strobe_d = 1'b1;
                    secure_d = bus.secure_in;
                    status_d = 1'b1;
                end
            end
            default: begin
                state_d  = SETTLE;
                settle_d = SETTLE_LOAD;
            end
        endcase
    end

    mrs_sat_cnt #(.W(CNT_W)) u_event_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.clr_status),
        .inc   (ev_inc),
        .q     (ev_q),
        .q_nxt (ev_nxt)
    );

    mrs_sat_cnt #(.W(CNT_W)) u_glitch_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.clr_status),
        .inc   (gl_inc),
        .q     (gl_q),
        .q_nxt (gl_nxt)
    );

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
        mrs_cause_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr     (bus.clr_status),
            .load    (mask_load),
            .accum   (mask_accum),
            .req_low (req_low[ch]),
            .q       (mask_q[ch]),
            .q_nxt   (mask_nxt[ch])
        );
    end

    // Status word mirrors the next field values so it lands on the same edge.
    always_comb begin
        data_d                       = '0;
        data_d[CNT_W-1:0]            = ev_nxt;
        data_d[2*CNT_W-1:CNT_W]      = gl_nxt;
        data_d[2*CNT_W +: NUM_CH]    = mask_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SETTLE;
            settle_q <= SETTLE_LOAD;
            status_q <= 1'b0;
            secure_q <= 1'b0;
            strobe_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            status_q <= status_d;
            secure_q <= secure_d;
            strobe_q <= strobe_d;
            data_q   <= data_d;
        end
    end

    assign bus.status     = status_q;
    assign bus.secure_out = secure_q;
    assign bus.strobe     = strobe_q;
    assign bus.data       = data_q;
endmodule

// File: tb/tb_multi_reset_sequencer.sv
// Directed bench for multi_reset_sequencer (NUM_CH=2, CNT_W=8, DATA_W=32, SETTLE_CYCLES=4).
module tb_multi_reset_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    multi_reset_sequencer_if #(.NUM_CH(2), .DATA_W(32)) bif ();

    multi_reset_sequencer #(
        .NUM_CH        (2),
        .CNT_W         (8),
        .DATA_W        (32),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic sec, input logic st,
                            input logic stb, input logic [31:0] d);
        chk({tag, ".secure_out"}, {31'd0, bif.secure_out}, {31'd0, sec});
        chk({tag, ".status"},     {31'd0, bif.status},     {31'd0, st});
        chk({tag, ".strobe"},     {31'd0, bif.strobe},     {31'd0, stb});
        chk({tag, ".data"},       bif.data,                d);
    endtask

    // Strobe must stay low for n-1 edges and pulse on the n-th; then drop.
    task automatic expect_strobe(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk($sformatf("%s.strobe_e%0d", tag, i), {31'd0, bif.strobe}, {31'd0, (i == n)});
        end
    endtask

    initial begin
        rst            = 1'b1;
        bif.rst_req_n  = 2'b11;
        bif.secure_in  = 1'b1;
        bif.clr_status = 1'b0;

        // 1. power-on recovery
        repeat (3) tick();
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        rst = 1'b0;
        expect_strobe("poweron", 4);
        chk_outs("poweron_done", 1'b1, 1'b1, 1'b1, 32'h0000_0000);
        tick();
        chk("poweron_strobe_drop", {31'd0, bif.strobe}, 32'd0);

        // 2. single-channel episode
        bif.rst_req_n = 2'b10;
        tick();
        chk_outs("ep1_start", 1'b0, 1'b0, 1'b0, 32'h0001_0001);
        repeat (2) tick();
        bif.rst_req_n = 2'b11;
        expect_strobe("ep1", 5);
        chk_outs("ep1_done", 1'b1, 1'b1, 1'b1, 32'h0001_0001);

        // 3. glitch on the 2nd settle cycle
        bif.rst_req_n = 2'b01;
        tick();
        chk("ep2_start.data", bif.data, 32'h0002_0002);
        bif.rst_req_n = 2'b11;
        tick();
        tick();
        bif.rst_req_n = 2'b10;
        tick();
        chk_outs("glitch", 1'b0, 1'b0, 1'b0, 32'h0003_0102);
        bif.rst_req_n = 2'b11;
        expect_strobe("glitch_rec", 5);
        chk_outs("glitch_done", 1'b1, 1'b1, 1'b1, 32'h0003_0102);

        // 4. saturation over 300 full episodes
        for (int e = 0; e < 300; e++) begin
            bif.rst_req_n = 2'b00;
            tick();
            bif.rst_req_n = 2'b11;
            repeat (5) tick();
        end
        chk_outs("saturate", 1'b1, 1'b1, 1'b1, 32'h0003_01FF);

        // 5. clear on the same edge as a new episode
        bif.clr_status = 1'b1;
        bif.rst_req_n  = 2'b01;
        tick();
        bif.clr_status = 1'b0;
        chk_outs("clr_new_ep", 1'b0, 1'b0, 1'b0, 32'h0002_0001);

        // 6. reset mid-episode
        bif.rst_req_n = 2'b10;
        tick();
        chk("in_reset_or.data", bif.data, 32'h0003_0001);
        rst = 1'b1;
        tick();
        chk_outs("mid_rst", 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        rst = 1'b0;
        tick();
        chk_outs("post_rst", 1'b0, 1'b0, 1'b0, 32'h0001_0100);
        bif.rst_req_n = 2'b11;
        expect_strobe("post_rst_rec", 5);
        chk_outs("post_rst_done", 1'b1, 1'b1, 1'b1, 32'h0001_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
